// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
//   state_t       : sequencer state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH : default operand width
//   ref_add       : reference result {ovf, cout, sum[31:0]} for widths 2..32
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sum is returned zero-extended in the low 32 bits; ovf/cout sit on top.
   function automatic logic [33:0] ref_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        cin,
                                           input int unsigned width);
      logic [31:0] mask;
      logic [32:0] full;
      logic [31:0] s;
      logic        co;
      logic        ov;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      full = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
      s    = full[31:0] & mask;
      co   = full[width];
      // same-sign operands producing a differently-signed result
      ov   = (a[width-1] == b[width-1]) && (s[width-1] != a[width-1]);
      return {ov, co, s};
   endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Handshake/data bundle between the user-project top level and the sequencer.
//   master : drives start/a/b/cin, observes busy/done/sum/cout/ovf
//   slave  : the sequencer side
interface serial_add_sequencer_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (output start, a, b, cin,
                   input  busy, done, sum, cout, ovf);
   modport slave  (input  start, a, b, cin,
                   output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_sequencer_full_adder_bit.sv
// Single-bit full adder cell, purely combinational.
//   i_x, i_y, i_ci : operand bits and carry-in
//   o_s, o_co      : sum bit and carry-out
module full_adder_bit (
   input  logic i_x,
   input  logic i_y,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   assign o_s  = i_x ^ i_y ^ i_ci;
   assign o_co = (i_x & i_y) | (i_ci & (i_x ^ i_y));
endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands and a carry-in
// on start, feeds one bit pair per clock (LSB first) through a single full
// adder cell and assembles sum, carry-out and signed overflow.
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous reset, active-high
//   io_bus : slave side of serial_add_sequencer_if
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start; result outputs hold
//   ST_RUN  | one bit per cycle, WIDTH cycles, busy high
//   ST_DONE | one cycle, done high, result valid
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   serial_add_sequencer_if.slave  io_bus
);
   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             r_ovf;

   logic w_s;
   logic w_co;

   full_adder_bit u_fa (
      .i_x  (r_a_sh[0]),
      .i_y  (r_b_sh[0]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (io_bus.start) begin
                  r_a_sh  <= io_bus.a;
                  r_b_sh  <= io_bus.b;
                  r_carry <= io_bus.cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_carry <= w_co;
               if (r_cnt == CNT_LAST) begin
                  // r_carry is the carry into the MSB on this last cycle, so
                  // cout/ovf are registered here and valid together with done.
                  r_cout  <= w_co;
                  r_ovf   <= r_carry ^ w_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign io_bus.busy = r_busy;
   assign io_bus.done = r_done;
   assign io_bus.sum  = r_sum;
   assign io_bus.cout = r_cout;
   assign io_bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;
   import serial_add_pkg::*;

   logic clk = 1'b0;
   logic rst8;
   logic rst4;

   always #5 clk = ~clk;

   serial_add_sequencer_if #(.WIDTH(8)) bus8 ();
   serial_add_sequencer_if #(.WIDTH(4)) bus4 ();

   serial_add_sequencer #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst(rst8), .io_bus(bus8));
   serial_add_sequencer #(.WIDTH(4)) dut4 (.i_clk(clk), .i_rst(rst4), .io_bus(bus4));

   int n_total = 0;
   int n_pass  = 0;
   int n_done8 = 0;
   int n_done4 = 0;

   logic [33:0] q8[$];
   logic [33:0] q4[$];

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   function automatic logic [33:0] e8(input logic ov, input logic co, input logic [7:0] s);
      return {ov, co, 24'd0, s};
   endfunction

   function automatic logic [33:0] act8();
      return {bus8.ovf, bus8.cout, 24'd0, bus8.sum};
   endfunction

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (bus8.done === 1'b1) begin
         n_done8++;
         if (q8.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done8: got done with %h required no done", act8());
         end else begin
            chk("result8", act8(), q8.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (bus4.done === 1'b1) begin
         n_done4++;
         if (q4.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done4: got done required no done");
         end else begin
            chk("result4", {bus4.ovf, bus4.cout, 28'd0, bus4.sum}, q4.pop_front());
         end
      end
   end

   // ---------------- WIDTH=8 helpers ----------------
   // Drives start for one cycle (called at posedge+1); returns at posedge+1
   // of the following cycle with operands scrambled to prove they are captured.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic push, input logic [33:0] exp);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = cin;
      if (push) q8.push_back(exp);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.a     = 8'hC3;
      bus8.b     = 8'h5A;
      bus8.cin   = 1'b1;
   endtask

   task automatic wait_done8(input string name);
      int k;
      for (k = 0; k < 40 && bus8.done !== 1'b1; k++) @(negedge clk);
      if (bus8.done !== 1'b1) begin
         n_total++;
         $display("FAIL %s_timeout: got no done required done within 40 cycles", name);
      end
      @(posedge clk); #1;
   endtask

   task automatic run8();
      int snap;
      // reset state
      @(negedge clk);
      chk("reset_outputs", {29'd0, bus8.busy, bus8.done, bus8.cout, bus8.ovf, 1'b0} | {26'd0, bus8.sum},
          34'd0);
      @(posedge clk); #1;

      // 0x35 + 0x1A: cycle-accurate busy/done timing
      issue8(8'h35, 8'h1A, 1'b0, 1'b1, e8(1'b0, 1'b0, 8'h4F));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("busy_done_c%0d", k), {32'd0, bus8.busy, bus8.done}, 34'b10);
      end
      @(negedge clk);
      chk("done_c9", {32'd0, bus8.busy, bus8.done}, 34'b01);
      @(negedge clk);
      chk("done_c10", {32'd0, bus8.busy, bus8.done}, 34'b00);
      chk("hold_c10", act8(), e8(1'b0, 1'b0, 8'h4F));
      repeat (2) @(negedge clk);
      chk("hold_c12", act8(), e8(1'b0, 1'b0, 8'h4F));
      @(posedge clk); #1;

      // carry / overflow corners
      issue8(8'hFF, 8'h01, 1'b0, 1'b1, e8(1'b0, 1'b1, 8'h00));
      wait_done8("ff_01");
      issue8(8'h7F, 8'h01, 1'b0, 1'b1, e8(1'b1, 1'b0, 8'h80));
      wait_done8("7f_01");
      issue8(8'h80, 8'h80, 1'b1, 1'b1, e8(1'b1, 1'b1, 8'h01));
      wait_done8("80_80");

      // starts during RUN (cycle 3) and DONE (cycle 9) are ignored; cycle 10 accepted
      snap = n_done8;
      issue8(8'h10, 8'h20, 1'b0, 1'b1, e8(1'b0, 1'b0, 8'h30));   // now cycle 1
      repeat (2) @(posedge clk);
      #1;                                                         // cycle 3
      bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
      @(posedge clk); #1;                                         // cycle 4
      bus8.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;                                                         // cycle 9
      bus8.start = 1'b1;
      @(posedge clk); #1;                                         // cycle 10
      issue8(8'hAA, 8'h55, 1'b0, 1'b1, e8(1'b0, 1'b0, 8'hFF));
      wait_done8("aa_55");
      repeat (3) @(negedge clk);
      chk("ignored_start_done_count", 34'(n_done8 - snap), 34'd2);
      @(posedge clk); #1;

      // reset mid-RUN aborts without done
      issue8(8'h0F, 8'h0F, 1'b0, 1'b0, '0);                       // now cycle 1
      repeat (3) @(posedge clk);
      #1;                                                         // cycle 4
      rst8 = 1'b1;
      snap = n_done8;
      @(posedge clk); #1;                                         // cycle 5
      rst8 = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {bus8.ovf, bus8.cout, 22'd0, bus8.busy, bus8.done, bus8.sum}, 34'd0);
      repeat (15) @(negedge clk);
      chk("abort_no_done", 34'(n_done8 - snap), 34'd0);
      @(posedge clk); #1;
      issue8(8'h0F, 8'h0F, 1'b0, 1'b1, e8(1'b0, 1'b0, 8'h1E));
      wait_done8("0f_0f");

      // rst and start together: reset wins
      snap = n_done8;
      rst8 = 1'b1;
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0;
      @(posedge clk); #1;
      rst8 = 1'b0;
      bus8.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("rst_start_busy_%0d", k), {33'd0, bus8.busy}, 34'd0);
      end
      chk("rst_start_no_done", 34'(n_done8 - snap), 34'd0);
   endtask

   // ---------------- WIDTH=4 exhaustive, back-to-back ----------------
   task automatic run4();
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               bus4.start = 1'b1;
               bus4.a     = 4'(ia);
               bus4.b     = 4'(ib);
               bus4.cin   = c[0];
               q4.push_back(ref_add(32'(ia), 32'(ib), c[0], 4));
               @(posedge clk); #1;
               bus4.start = 1'b0;
               bus4.a     = ~4'(ia);
               bus4.b     = ~4'(ib);
               bus4.cin   = ~c[0];
               // next start lands exactly WIDTH+2 cycles after the previous one
               repeat (5) @(posedge clk);
               #1;
            end
         end
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst8 = 1'b1; rst4 = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0; rst4 = 1'b0;
      fork
         run8();
         run4();
      join
      repeat (10) @(negedge clk);
      chk("done4_count", 34'(n_done4), 34'd512);
      chk("q8_drained", 34'(q8.size()), 34'd0);
      chk("q4_drained", 34'(q4.size()), 34'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion required finish before 500000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
